switch_egress_port: RTL and testbench

Egress-side receiver for one output of the switch fabric. It captures each `data_out_valid`/`data_out` word the fabric emits and buffers it in a show-ahead FIFO. It presents the words to a downstream consumer over a valid/ready handshake. The fabric output has no backpressure, so the block accounts for every word: accepted words are counted, words arriving with no room are dropped, counted, and flagged.

---
 rtl/switch_egress_port_if.sv | 32 +++
 rtl/switch_egress_port.sv | 108 ++++++++++
 tb/tb_switch_egress_port.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/switch_egress_port_if.sv
// Egress port bundle: fabric capture input, downstream show-ahead read port, occupancy and statistics.
// master: seen from the egress port (drives out_*, level, almost_full, overflow, counters).
// slave:  seen from the surrounding logic (drives in_*, out_ready, clear_stats).
interface switch_egress_port_if #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = 32
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   logic [LW-1:0]         level;
   logic                  almost_full;
   logic                  overflow;
   logic [CNT_WIDTH-1:0]  accept_count;
   logic [CNT_WIDTH-1:0]  drop_count;
   logic                  clear_stats;

   modport master (
      input  in_valid, in_data, out_ready, clear_stats,
      output out_valid, out_data, level, almost_full, overflow, accept_count, drop_count
   );

   modport slave (
      output in_valid, in_data, out_ready, clear_stats,
      input  out_valid, out_data, level, almost_full, overflow, accept_count, drop_count
   );
endinterface

// File: rtl/switch_egress_port.sv
// Egress receiver for one fabric output: captures every valid fabric word into a show-ahead FIFO.
// Latency: a word captured at edge N is presented from cycle N+1 (no empty bypass).
// Backpressure: the fabric cannot be stalled; words arriving while full (and no pop) are dropped and counted.
// Ports: clk, reset (sync, active-high); bus (master modport): in_valid/in_data from the fabric,
//        out_valid/out_data/out_ready to the consumer, level/almost_full occupancy,
//        overflow/accept_count/drop_count statistics, clear_stats pulse.
module switch_egress_port #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = 12,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   switch_egress_port_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]          PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0]          AF_THRESH = (AW+1)'(AF_LEVEL);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;
   logic [AW:0]           r_level;
   logic                  r_almost_full;
   logic                  r_overflow;
   logic [CNT_WIDTH-1:0]  r_accept_count;
   logic [CNT_WIDTH-1:0]  r_drop_count;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic [AW:0]           w_level_nxt;

   always_comb begin
      w_empty = (r_rd_ptr == r_wr_ptr);
      // Same slot index but different lap: writer is exactly one lap ahead.
      w_full  = (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]) && (r_rd_ptr[AW] != r_wr_ptr[AW]);
      w_pop   = !w_empty && bus.out_ready;
      // A pop frees the head slot at the same edge, so a full buffer can still take a word.
      w_push  = bus.in_valid && (!w_full || w_pop);
      w_drop  = bus.in_valid && w_full && !w_pop;

      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + PTR_ONE;
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - PTR_ONE;
      end
   end

   // Storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_level        <= '0;
         r_almost_full  <= 1'b0;
         r_overflow     <= 1'b0;
         r_accept_count <= '0;
         r_drop_count   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         r_level       <= w_level_nxt;
         r_almost_full <= (w_level_nxt >= AF_THRESH);

         // Clear takes priority: a same-cycle push/drop is neither counted nor flagged.
         if (bus.clear_stats) begin
            r_accept_count <= '0;
            r_drop_count   <= '0;
            r_overflow     <= 1'b0;
         end else begin
            if (w_push && (r_accept_count != CNT_MAX)) begin
               r_accept_count <= r_accept_count + CNT_ONE;
            end
            if (w_drop) begin
               r_overflow <= 1'b1;
               if (r_drop_count != CNT_MAX) begin
                  r_drop_count <= r_drop_count + CNT_ONE;
               end
            end
         end
      end
   end

   assign bus.out_valid    = !w_empty;
   assign bus.out_data     = r_mem[r_rd_ptr[AW-1:0]];
   assign bus.level        = r_level;
   assign bus.almost_full  = r_almost_full;
   assign bus.overflow     = r_overflow;
   assign bus.accept_count = r_accept_count;
   assign bus.drop_count   = r_drop_count;
endmodule

// File: tb/tb_switch_egress_port.sv
// Testbench for switch_egress_port: table-driven vectors, hand-written corner sequences and a
// random stream, all checked against a queue-based reference model. A second instance with
// narrow counters exercises counter saturation.
module tb_switch_egress_port;
   localparam int DW    = 64;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int CW    = 32;
   localparam int SCW   = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   switch_egress_port_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW))  bus  ();
   switch_egress_port_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(SCW)) sbus ();

   switch_egress_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   switch_egress_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .CNT_WIDTH(SCW)) dut_s (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus.master)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: a queue plus counters ----------------
   logic [DW-1:0] mq[$];
   longint m_acc, m_drop;
   bit     m_ovf;
   longint cmax = (longint'(1) << CW) - 1;

   function automatic void model_step(bit rst, bit iv, logic [DW-1:0] d, bit rdy, bit clr);
      bit pop, full, push, drop;
      if (rst) begin
         mq.delete();
         m_acc = 0; m_drop = 0; m_ovf = 0;
         return;
      end
      pop  = (mq.size() > 0) && rdy;
      full = (mq.size() == DEPTH);
      push = iv && (!full || pop);
      drop = iv && full && !pop;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
      if (clr) begin
         m_acc = 0; m_drop = 0; m_ovf = 0;
      end else begin
         if (push && m_acc < cmax) m_acc++;
         if (drop) begin
            m_ovf = 1;
            if (m_drop < cmax) m_drop++;
         end
      end
   endfunction

   task automatic check_model(string tag);
      chk({tag, " out_valid"}, bus.out_valid, mq.size() != 0);
      if (mq.size() != 0) chk({tag, " out_data"}, bus.out_data, mq[0]);
      chk({tag, " level"}, bus.level, mq.size());
      chk({tag, " almost_full"}, bus.almost_full, mq.size() >= AF);
      chk({tag, " overflow"}, bus.overflow, m_ovf);
      chk({tag, " accept_count"}, bus.accept_count, m_acc);
      chk({tag, " drop_count"}, bus.drop_count, m_drop);
   endtask

   // One clock on the main instance: drive, advance the model, sample 1 time unit after the edge.
   task automatic cyc(bit iv, logic [DW-1:0] d, bit rdy, bit clr, string tag);
      bus.in_valid    = iv;
      bus.in_data     = d;
      bus.out_ready   = rdy;
      bus.clear_stats = clr;
      model_step(0, iv, d, rdy, clr);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic do_reset(bit iv);
      reset = 1'b1;
      bus.in_valid = iv; bus.in_data = 64'hDEAD; bus.out_ready = 1'b0; bus.clear_stats = 1'b0;
      model_step(1, iv, 64'hDEAD, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_model("reset");
      chk("small reset accept_count", sbus.accept_count, 0);
      chk("small reset drop_count", sbus.drop_count, 0);
      chk("small reset out_valid", sbus.out_valid, 0);
   endtask

   // Clock for the narrow-counter instance; the main instance idles meanwhile.
   task automatic scyc(bit iv, bit rdy, bit clr);
      sbus.in_valid    = iv;
      sbus.in_data     = 64'h77;
      sbus.out_ready   = rdy;
      sbus.clear_stats = clr;
      cyc(0, '0, 0, 0, "idle");
   endtask

   typedef struct {
      bit          iv;
      logic [63:0] d;
      bit          rdy;
      bit          ev;
      logic [63:0] ed;
      int          el;
      int          eacc;
   } vec_t;

   vec_t vt[10];

   initial begin
      int sent, recvd, guard;
      bit iv, rdy;
      longint drop_before;

      vt[0] = '{1, 64'hA0, 0, 1, 64'hA0, 1, 1};
      vt[1] = '{1, 64'hA1, 0, 1, 64'hA0, 2, 2};
      vt[2] = '{1, 64'hA2, 0, 1, 64'hA0, 3, 3};
      vt[3] = '{1, 64'hA3, 0, 1, 64'hA0, 4, 4};
      vt[4] = '{0, 64'h0,  1, 1, 64'hA1, 3, 4};
      vt[5] = '{0, 64'h0,  1, 1, 64'hA2, 2, 4};
      vt[6] = '{0, 64'h0,  1, 1, 64'hA3, 1, 4};
      vt[7] = '{0, 64'h0,  1, 0, 64'h0,  0, 4};
      vt[8] = '{1, 64'h55, 1, 1, 64'h55, 1, 5};
      vt[9] = '{0, 64'h0,  1, 0, 64'h0,  0, 5};

      sbus.in_valid = 0; sbus.in_data = '0; sbus.out_ready = 0; sbus.clear_stats = 0;
      do_reset(0);
      chk("reset level", bus.level, 0);
      chk("reset out_valid", bus.out_valid, 0);

      // Table vectors: four-word burst, drain, then single-word latency.
      for (int i = 0; i < 10; i++) begin
         cyc(vt[i].iv, vt[i].d, vt[i].rdy, 0, "vec");
         chk($sformatf("vec%0d out_valid", i), bus.out_valid, vt[i].ev);
         if (vt[i].ev) chk($sformatf("vec%0d out_data", i), bus.out_data, vt[i].ed);
         chk($sformatf("vec%0d level", i), bus.level, vt[i].el);
         chk($sformatf("vec%0d accept_count", i), bus.accept_count, vt[i].eacc);
      end

      // Fill to DEPTH, then three drops.
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 64'h200 + i, 0, 0, "fill");
         if (i == AF - 2) chk("almost_full below threshold", bus.almost_full, 0);
         if (i == AF - 1) chk("almost_full at threshold", bus.almost_full, 1);
      end
      for (int i = 0; i < 3; i++) cyc(1, 64'h2F0 + i, 0, 0, "drop");
      chk("full level", bus.level, 16);
      chk("full drop_count", bus.drop_count, 3);
      chk("full overflow", bus.overflow, 1);
      chk("full accept_count", bus.accept_count, 21);

      // Full with simultaneous push and pop: no drops, level holds.
      for (int i = 0; i < 10; i++) cyc(1, 64'h300 + i, 1, 0, "full push+pop");
      chk("push+pop level", bus.level, 16);
      chk("push+pop drop_count", bus.drop_count, 3);
      chk("push+pop head", bus.out_data, 64'h20A);

      // Clear coincident with a drop.
      cyc(1, 64'h3F0, 0, 1, "clear+drop");
      chk("clear drop_count", bus.drop_count, 0);
      chk("clear overflow", bus.overflow, 0);
      chk("clear level", bus.level, 16);
      cyc(1, 64'h3F1, 0, 0, "drop after clear");
      chk("drop after clear count", bus.drop_count, 1);
      cyc(0, '0, 0, 1, "clear alone");
      chk("clear alone overflow", bus.overflow, 0);

      for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1, 0, "drain");
      chk("drained out_valid", bus.out_valid, 0);

      // Random stream of 100 words, ready duty about 75%, never overfilling.
      drop_before = m_drop;
      sent = 0; recvd = 0; guard = 0;
      while ((sent < 100 || mq.size() > 0) && guard < 3000) begin
         rdy = ($urandom_range(0, 3) != 0);
         iv  = (sent < 100) && ($urandom_range(0, 9) < 7) && !(mq.size() == DEPTH && !rdy);
         if (bus.out_valid && rdy) begin
            chk("stream order", bus.out_data, 64'h1000 + recvd);
            recvd++;
         end
         cyc(iv, 64'h1000 + sent, rdy, 0, "stream");
         if (iv) sent++;
         guard++;
      end
      chk("stream words received", recvd, 100);
      chk("stream no drops", bus.drop_count, drop_before);

      // Reset mid-operation with in_valid high in the reset cycle.
      for (int i = 0; i < 5; i++) cyc(1, 64'h500 + i, 0, 0, "pre-reset");
      do_reset(1);
      cyc(0, '0, 1, 0, "post-reset");
      chk("post-reset out_valid", bus.out_valid, 0);
      chk("post-reset accept_count", bus.accept_count, 0);

      // Narrow counters: preload to max-1, then two more events saturate.
      for (int i = 0; i < 6; i++) scyc(1, 1, 0);
      chk("small accept preload", sbus.accept_count, 6);
      for (int i = 0; i < 2; i++) scyc(1, 1, 0);
      chk("small accept saturate", sbus.accept_count, 7);
      scyc(1, 1, 0);
      chk("small accept hold", sbus.accept_count, 7);
      scyc(0, 1, 0);
      for (int i = 0; i < DEPTH; i++) scyc(1, 0, 0);
      chk("small full level", sbus.level, 16);
      for (int i = 0; i < 6; i++) scyc(1, 0, 0);
      chk("small drop preload", sbus.drop_count, 6);
      for (int i = 0; i < 2; i++) scyc(1, 0, 0);
      chk("small drop saturate", sbus.drop_count, 7);
      scyc(1, 0, 0);
      chk("small drop hold", sbus.drop_count, 7);
      chk("small overflow", sbus.overflow, 1);
      scyc(0, 0, 1);
      chk("small clear drop", sbus.drop_count, 0);
      chk("small clear accept", sbus.accept_count, 0);
      chk("small clear overflow", sbus.overflow, 0);
      chk("small clear keeps level", sbus.level, 16);
      scyc(0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
